// File: rtl/divider_iter.sv
// divider_iter: multi-cycle radix-2 restoring integer divider for the EX stage.
// Each cycle produces one quotient bit from the operand magnitudes. The signs
// are applied in a final FIX cycle. Results follow MIPS HI/LO semantics:
// lo is the quotient and hi is the remainder.
//
// Optional build macro: DIV_EARLY_OUT_EN. When it is defined, an operation
// skips CALC if the divisor is zero or |srca| < |srcb|.
//
// Handshake: start is sampled only in IDLE. busy is high while an operation is
// in flight. done is a one-cycle pulse, and hi/lo are valid from that cycle
// until the next FIX. cancel has the highest priority. It drops any in-flight
// operation without a done pulse and leaves hi/lo unchanged. In IDLE, cancel
// also blocks start. A start that arrives while busy is ignored.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   start, sign, cancel request / signed(1)-unsigned(0) / flush
//   srca, srcb          dividend / divisor, sampled with start
//   busy, done          operation in flight / result pulse
//   hi, lo              remainder / quotient registers
//   state_o             debug view of the FSM state
module divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              sign_q, a_neg_q, b_neg_q;
  logic [WIDTH-1:0]  srca_q;
  logic [WIDTH-1:0]  dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]  dvs_q;   // divisor magnitude
  logic [WIDTH-1:0]  rem_q;   // partial remainder
  logic              busy_q, done_q;
  logic [WIDTH-1:0]  hi_q, lo_q;

  // Operand magnitudes, as seen in IDLE.
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              early;
  // One restoring step.
  logic [WIDTH:0]    shift_w;
  logic              q_bit;
  logic [WIDTH-1:0]  rem_d, dvd_d;
  // Sign fix-up.
  logic              q_neg, r_neg;
  logic [WIDTH-1:0]  quo_fix_d, rem_fix_d;

  always_comb begin
    a_mag = (sign && srca[WIDTH-1]) ? -srca : srca;
    b_mag = (sign && srcb[WIDTH-1]) ? -srcb : srcb;
`ifdef DIV_EARLY_OUT_EN
    early = (b_mag == '0) || (a_mag < b_mag);
`else
    early = 1'b0;
`endif
    // The compare is WIDTH+1 bits wide, so the bit shifted out of rem_q is
    // never lost.
    shift_w = {rem_q, dvd_q[WIDTH-1]};
    q_bit   = (shift_w >= {1'b0, dvs_q});
    rem_d   = q_bit ? (shift_w[WIDTH-1:0] - dvs_q) : shift_w[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], q_bit};

    q_neg     = sign_q & (a_neg_q ^ b_neg_q);
    r_neg     = sign_q & a_neg_q;
    quo_fix_d = q_neg ? -dvd_q : dvd_q;
    rem_fix_d = r_neg ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      srca_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !cancel) begin
            sign_q  <= sign;
            a_neg_q <= srca[WIDTH-1];
            b_neg_q <= srcb[WIDTH-1];
            srca_q  <= srca;
            dvs_q   <= b_mag;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            if (early) begin
              // Quotient is 0 and the remainder is the whole dividend.
              rem_q   <= a_mag;
              dvd_q   <= '0;
              state_q <= S_FIX;
            end else begin
              rem_q   <= '0;
              dvd_q   <= a_mag;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            if (cnt_q == '0) state_q <= S_FIX;
            else             cnt_q   <= cnt_q - CW'(1);
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!cancel) begin
            done_q <= 1'b1;
            if (dvs_q == '0) begin
              lo_q <= '1;
              hi_q <= srca_q;
            end else begin
              lo_q <= quo_fix_d;
              hi_q <= rem_fix_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_divider_iter.sv
// Testbench for divider_iter. One instance uses WIDTH=32 for directed and
// random operations, plus cancel, reset and handshake cases. A second instance
// uses WIDTH=8 for a random sweep. Results and latencies are compared against
// an arithmetic reference model.
module tb_divider_iter;

  localparam int W  = 32;
  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start = 1'b0, sign = 1'b0, cancel = 1'b0;
  logic [W-1:0]  srca = '0, srcb = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;
  logic [1:0]    state32;

  logic          s8_start = 1'b0, s8_sign = 1'b0, s8_cancel = 1'b0;
  logic [W8-1:0] s8_srca = '0, s8_srcb = '0;
  logic          s8_busy, s8_done;
  logic [W8-1:0] s8_hi, s8_lo;
  logic [1:0]    state8;

  divider_iter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .sign(sign), .cancel(cancel),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .state_o(state32)
  );

  divider_iter #(.WIDTH(W8)) dut8 (
    .clk(clk), .resetn(resetn), .start(s8_start), .sign(s8_sign), .cancel(s8_cancel),
    .srca(s8_srca), .srcb(s8_srcb), .busy(s8_busy), .done(s8_done), .hi(s8_hi), .lo(s8_lo),
    .state_o(state8)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [63:0] exp_q[$];   // {hi, lo} expected
  int          lat_q[$];   // expected done edge

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended values.
  function automatic logic [63:0] ref_div(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sg);
    longint     mask, ua, ub, sa, sb, q, r;
    logic [31:0] m32, q32, r32;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (sg && ua[w-1]) ? ua - (mask + 1) : ua;
    sb = (sg && ub[w-1]) ? ub - (mask + 1) : ub;
    if (ub == 0) begin
      q = mask;
      r = ua;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    m32 = mask[31:0];
    q32 = q[31:0] & m32;
    r32 = r[31:0] & m32;
    return {r32, q32};
  endfunction

  function automatic int ref_lat(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic sg);
`ifdef DIV_EARLY_OUT_EN
    longint mask, ua, ub, sa, sb;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (sg && ua[w-1]) ? ua - (mask + 1) : ua;
    sb = (sg && ub[w-1]) ? ub - (mask + 1) : ub;
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (ub == 0 || sa < sb) return 1;
`endif
    return w + 1;
  endfunction

  // ---------------- driver tasks (WIDTH=32 instance) ----------------
  // Called at a negedge; the following posedge is edge 0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
    start = 1'b1;
    srca  = a;
    srcb  = b;
    sign  = sg;
    exp_q.push_back(ref_div(W, a, b, sg));
    lat_q.push_back(ref_lat(W, a, b, sg));
  endtask

  task automatic wait_done(input string tag);
    int          edges;
    bit          busy_ok;
    logic [63:0] e;
    int          lat;
    edges   = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_e0"}, 64'(busy), 64'd1);
    while (!done && edges < 2 * W + 8) begin
      @(negedge clk);
      edges++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    e   = exp_q.pop_front();
    lat = lat_q.pop_front();
    chk({tag, ".lat"}, 64'(edges), 64'(lat));
    chk({tag, ".busy_held"}, 64'(busy_ok), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".lo"}, 64'(lo), 64'(e[31:0]));
    chk({tag, ".hi"}, 64'(hi), 64'(e[63:32]));
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({tag, ".no_done"}, 64'(seen), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dir_a [9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000,
                             32'd3, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFF0};
  logic [31:0] dir_b [9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,
                             32'd10, 32'd5, 32'd10, 32'd0};
  logic        dir_s [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    logic [63:0] prev;
    logic [63:0] e;
    int          lat, edges;
    logic [31:0] ra, rb;
    logic        rs;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi",   64'(hi),   64'd0);
    chk("rst.lo",   64'(lo),   64'd0);
    chk("rst8.busy", 64'(s8_busy), 64'd0);
    chk("rst8.lo",   64'(s8_lo),   64'd0);
    resetn = 1'b1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      issue(dir_a[i], dir_b[i], dir_s[i]);
      wait_done($sformatf("dir%0d", i));
    end

    // Random operations, with a mix of small and zero divisors
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      @(negedge clk);
      issue(ra, rb, rs);
      wait_done($sformatf("rnd%0d", i));
    end

    // Cancel mid-operation: hi/lo keep the previous result and there is no done
    prev = {hi, lo};
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel.busy", 64'(busy), 64'd0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    expect_no_done("cancel", 40);
    chk("cancel.keep", {hi, lo}, prev);
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    wait_done("after_cancel");

    // A start together with cancel in IDLE is ignored
    @(negedge clk);
    start  = 1'b1;
    cancel = 1'b1;
    srca   = 32'd9;
    srcb   = 32'd2;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    chk("idle_cancel.busy", 64'(busy), 64'd0);
    expect_no_done("idle_cancel", 40);

    // A start while busy is ignored and not queued
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    srca  = 32'd50;
    srcb  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    edges = 5;
    while (!done && edges < 3 * W) begin
      @(negedge clk);
      edges++;
    end
    e   = exp_q.pop_front();
    lat = lat_q.pop_front();
    chk("busy_start.lat", 64'(edges), 64'(lat));
    chk("busy_start.lo", 64'(lo), 64'(e[31:0]));
    chk("busy_start.hi", 64'(hi), 64'(e[63:32]));
    expect_no_done("busy_start", 40);

    // Back-to-back: a new start in the done cycle is accepted
    @(negedge clk);
    issue(32'd1000, 32'd3, 1'b0);
    wait_done("b2b_first");
    issue(32'd50, 32'd5, 1'b0);
    wait_done("b2b_second");

    // Asynchronous reset mid-operation
    @(negedge clk);
    issue(32'd12345, 32'd17, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst.busy", 64'(busy), 64'd0);
    chk("mid_rst.hi",   64'(hi),   64'd0);
    chk("mid_rst.lo",   64'(lo),   64'd0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(negedge clk);
    resetn = 1'b1;
    expect_no_done("mid_rst", 40);

    // WIDTH=8 random sweep, with corner cases first
    for (int i = 0; i < 64; i++) begin
      case (i)
        0: begin ra = 32'h80; rb = 32'hFF; rs = 1'b1; end
        1: begin ra = 32'h80; rb = 32'h00; rs = 1'b0; end
        2: begin ra = 32'h00; rb = 32'h03; rs = 1'b1; end
        3: begin ra = 32'h81; rb = 32'h7F; rs = 1'b1; end
        default: begin
          ra = 32'($urandom_range(0, 255));
          rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
          rs = 1'($urandom_range(0, 1));
        end
      endcase
      e   = ref_div(W8, ra, rb, rs);
      lat = ref_lat(W8, ra, rb, rs);
      @(negedge clk);
      s8_start = 1'b1;
      s8_srca  = ra[7:0];
      s8_srcb  = rb[7:0];
      s8_sign  = rs;
      @(negedge clk);
      s8_start = 1'b0;
      edges = 0;
      while (!s8_done && edges < 40) begin
        @(negedge clk);
        edges++;
      end
      chk($sformatf("w8_%0d.lat", i), 64'(edges), 64'(lat));
      chk($sformatf("w8_%0d.lo", i), 64'(s8_lo), 64'(e[7:0]));
      chk($sformatf("w8_%0d.hi", i), 64'(s8_hi), 64'(e[39:32]));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/divider_iter.md
# divider_iter

Multi-cycle iterative integer divider for the EX stage, succeeding the single-cycle combinational divider. It runs a radix-2 restoring division on operand magnitudes, one quotient bit per clock, and applies correct two's-complement signs at the end. It uses a start/busy/done handshake and a pipeline-flush cancel, so the EX stage can stall on DIV/DIVU and drop the operation on an exception. Results follow MIPS HI/LO semantics: `lo` holds the quotient and `hi` holds the remainder.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `resetn` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: request a division; sampled only in IDLE.
- `sign` input, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `cancel` input, 1 bit: flush; abort any in-flight operation.
- `srca` input, WIDTH bits: dividend; sampled with `start`.
- `srcb` input, WIDTH bits: divisor; sampled with `start`.
- `busy` output, 1 bit: operation in flight.
- `done` output, 1 bit: one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi` output, WIDTH bits: remainder register.
- `lo` output, WIDTH bits: quotient register.

## Operation
- **States:** IDLE, CALC, FIX.
- **Reset values:** all outputs 0; state IDLE; counter 0.
- **IDLE, `start`=1, `cancel`=0:**
  - latch `sign`, the sign bits of `srca`/`srcb`, and `srca`.
  - latch operand magnitudes: two's-complement absolute value when `sign`=1, raw value otherwise.
  - clear the partial remainder; set counter = WIDTH−1; go to CALC.
- **CALC, each cycle:**
  - shift the partial remainder left, bringing in the next dividend bit (MSB first).
  - if remainder ≥ divisor magnitude: subtract, quotient bit = 1; otherwise quotient bit = 0.
  - comparison and subtraction are WIDTH+1 bits wide so no carry is lost.
  - at counter 0, go to FIX; otherwise decrement.
- **FIX (one cycle):**
  - signed quotient negative iff sign(srca) ≠ sign(srcb).
  - signed remainder takes the sign of the dividend.
  - register results into `hi`/`lo`; pulse `done`; return to IDLE.
- **Divide by zero (`srcb`=0):** the full latency still applies; result `lo` = all ones, `hi` = latched `srca`, for both signed and unsigned.
- **Signed overflow (MIN / −1):** `lo` = MIN (wraps), `hi` = 0. No trap; traps are handled elsewhere.
- **Holding results:** `hi`/`lo` hold their value until the next FIX. They are never cleared by `start` or `cancel`.
- **`cancel` priority:** highest.
  - in CALC or FIX: go to IDLE next edge, no `done`, `hi`/`lo` unchanged.
  - in IDLE together with `start`: `start` is ignored.
- **`start` while busy:** ignored; no queueing.

## Timing
- Edge 0 is the edge that samples `start`.
- `busy` = 1 from edge 0 until edge WIDTH+1.
- At edge WIDTH+1, `done` rises, `busy` falls, and `hi`/`lo` update; `done` falls at edge WIDTH+2.
- Latency is WIDTH+1 cycles: 33 for WIDTH=32.
- A new `start` may be presented in the same cycle `done` is high; it is accepted at edge WIDTH+2.
- Asserting `resetn` low mid-operation immediately forces IDLE with all outputs 0; no `done`.
- No combinational path from any input to any output.

## Configuration
- **`DIV_EARLY_OUT_EN` defined:** when, in IDLE, `srcb`=0 or |srca| < |srcb| (magnitudes per `sign`, including `srca`=0), the block skips CALC and goes straight to FIX.
  - `done` rises at edge 1.
  - results are `lo`=0, `hi`=`srca` in the normal case.
  - divide by zero still gives `lo` = all ones, `hi`=`srca`.
- **Not defined:** every operation takes WIDTH+1 cycles; results are identical in both builds.

## Test plan
- Unsigned 100 / 7, WIDTH=32 → `done` at edge 33, `lo`=14, `hi`=2, `busy` high for edges 0–32.
- Signed 0xFFFFFFF9 / 2 (−7/2) → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Signed 7 / 0xFFFFFFFE → `lo`=0xFFFFFFFD, `hi`=1.
- Signed 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Unsigned 0x80000000 / 0 → `lo`=0xFFFFFFFF, `hi`=0x80000000.
- Start 100/7, assert `cancel` at edge 10 → `busy` low at edge 11, no `done`, `hi`/`lo` keep the prior result. Assert `start` again at edge 15 → correct result at edge 48.
- Second `start` (50/5) at edge 5 during a busy operation → ignored; only the first result appears. Back-to-back `start` in the `done` cycle → accepted, second `done` 33 cycles later.
- Early-out build: 3/10 → `done` at edge 1, `lo`=0, `hi`=3. Without the macro → `done` at edge 33, same values. Also sweep WIDTH=8 with random operands against a reference model.
